// File: rtl/div_rem_sequencer.sv
// Multi-cycle RV32M divider: DIV/DIVU/REM/REMU via radix-2 restoring division,
// with a one-cycle fast path for divide-by-zero, signed overflow and illegal ops.
module div_rem_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            kill_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [XLEN-1:0] res_o,
  output logic            busy_o
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0]  ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]  ONES     = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN-1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
    return (~v) + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  state_t            state_r;
  logic [2:0]        op_r;
  logic [XLEN-1:0]   a_r, b_r, q_r, rem_r, div_r, res_r;
  logic              neg_q_r, neg_r_r, res_valid_r;
  logic [CNT_W-1:0]  cnt_r;

  logic              signed_op_s, rem_op_s, fast_s;
  logic [XLEN-1:0]   fast_res_s, a_abs_s, b_abs_s;
  logic [XLEN:0]     rem_shift_s, diff_s;
  logic              ge_s;
  logic [XLEN-1:0]   rem_next_s, q_next_s, q_fix_s, rem_fix_s;

  assign req_ready_o = (state_r == S_IDLE) & ~kill_i;
  assign busy_o      = (state_r != S_IDLE);
  assign res_valid_o = res_valid_r;
  assign res_o       = res_r;

  // Operand classification and fast-path result for special cases
  always_comb begin
    signed_op_s = ~op_r[0];
    rem_op_s    = op_r[1];
    fast_s      = 1'b1;
    fast_res_s  = ZERO;
    if (!op_r[2]) begin
      fast_res_s = ZERO;
    end else if (b_r == ZERO) begin
      fast_res_s = rem_op_s ? a_r : ONES;
    end else if (signed_op_s && (a_r == INT_MIN) && (b_r == ONES)) begin
      fast_res_s = rem_op_s ? ZERO : INT_MIN;
    end else begin
      fast_s     = 1'b0;
      fast_res_s = ZERO;
    end
  end

  // Magnitudes, one restoring step (XLEN+1 wide) and final sign fix-up
  always_comb begin
    a_abs_s     = (signed_op_s && a_r[XLEN-1]) ? negate(a_r) : a_r;
    b_abs_s     = (signed_op_s && b_r[XLEN-1]) ? negate(b_r) : b_r;
    rem_shift_s = {rem_r, q_r[XLEN-1]};
    diff_s      = rem_shift_s - {1'b0, div_r};
    ge_s        = ~diff_s[XLEN];
    rem_next_s  = ge_s ? diff_s[XLEN-1:0] : rem_shift_s[XLEN-1:0];
    q_next_s    = {q_r[XLEN-2:0], ge_s};
    q_fix_s     = neg_q_r ? negate(q_r) : q_r;
    rem_fix_s   = neg_r_r ? negate(rem_r) : rem_r;
  end

  // Control FSM and datapath registers; kill overrides every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      op_r        <= 3'b000;
      a_r         <= ZERO;
      b_r         <= ZERO;
      q_r         <= ZERO;
      rem_r       <= ZERO;
      div_r       <= ZERO;
      res_r       <= ZERO;
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      res_valid_r <= 1'b0;
      cnt_r       <= CNT_ZERO;
    end else if (kill_i) begin
      state_r     <= S_IDLE;
      res_valid_r <= 1'b0;
      res_r       <= ZERO;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (req_valid_i) begin
            op_r    <= op_i;
            a_r     <= a_i;
            b_r     <= b_i;
            state_r <= S_PREP;
          end
        end
        S_PREP: begin
          if (fast_s) begin
            res_r       <= fast_res_s;
            res_valid_r <= 1'b1;
            state_r     <= S_DONE;
          end else begin
            q_r     <= a_abs_s;
            div_r   <= b_abs_s;
            rem_r   <= ZERO;
            neg_q_r <= signed_op_s & (a_r[XLEN-1] ^ b_r[XLEN-1]);
            neg_r_r <= signed_op_s & a_r[XLEN-1];
            cnt_r   <= CNT_LAST;
            state_r <= S_ITER;
          end
        end
        S_ITER: begin
          rem_r <= rem_next_s;
          q_r   <= q_next_s;
          cnt_r <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ZERO) begin
            state_r <= S_FIX;
          end
        end
        S_FIX: begin
          res_r       <= rem_op_s ? rem_fix_s : q_fix_s;
          res_valid_r <= 1'b1;
          state_r     <= S_DONE;
        end
        S_DONE: begin
          if (res_ready_i) begin
            res_valid_r <= 1'b0;
            state_r     <= S_IDLE;
          end
        end
        default: begin
          res_valid_r <= 1'b0;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_rem_sequencer.sv
// Directed self-checking bench for div_rem_sequencer: results, latency,
// back-pressure, flush and asynchronous reset behaviour.
module tb_div_rem_sequencer;

  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;

  logic        clk         = 1'b0;
  logic        rst_n       = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        kill_i      = 1'b0;
  logic        res_ready_i = 1'b0;
  logic [2:0]  op_i        = 3'b000;
  logic [31:0] a_i         = 32'h0;
  logic [31:0] b_i         = 32'h0;
  logic        req_ready_o, res_valid_o, busy_o;
  logic [31:0] res_o;

  int n_checks = 0;
  int n_pass   = 0;

  div_rem_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .op_i(op_i), .a_i(a_i), .b_i(b_i), .kill_i(kill_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_o(res_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Issue one request, scramble inputs after acceptance, count edges to res_valid_o
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res);
    op_i = op; a_i = a; b_i = b; req_valid_i = 1'b1;
    @(posedge clk); #1;
    req_valid_i = 1'b0; op_i = 3'b001; a_i = ~a; b_i = 32'h5;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (res_valid_o) begin
        lat = i;
        break;
      end
    end
    res = res_o;
  endtask

  task automatic release_res();
    res_ready_i = 1'b1;
    @(posedge clk); #1;
    res_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({res_valid_o, busy_o} !== 2'b00) $display("FAIL reset_flags: got valid=%b busy=%b required 0 0", res_valid_o, busy_o);
    else n_pass++;
    n_checks++;
    if (res_o !== 32'h0) $display("FAIL reset_res: got %h required 00000000", res_o);
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (req_ready_o !== 1'b1) $display("FAIL reset_ready: got %b required 1", req_ready_o);
    else n_pass++;
  endtask

  task automatic test_signed();
    int lat; logic [31:0] r;
    run_op(OP_DIV, 32'd20, 32'hFFFF_FFFD, lat, r);
    n_checks++;
    if (r !== 32'hFFFF_FFFA) $display("FAIL div_20_m3: got %h required fffffffa", r);
    else n_pass++;
    n_checks++;
    if (lat !== 34) $display("FAIL div_latency: got %0d required 34", lat);
    else n_pass++;
    release_res();
    n_checks++;
    if ({res_valid_o, busy_o} !== 2'b00) $display("FAIL div_release: got valid=%b busy=%b required 0 0", res_valid_o, busy_o);
    else n_pass++;
    run_op(OP_REM, 32'd20, 32'hFFFF_FFFD, lat, r);
    n_checks++;
    if ({r, lat} !== {32'h2, 32'd34}) $display("FAIL rem_20_m3: got %h lat %0d required 00000002 lat 34", r, lat);
    else n_pass++;
    release_res();
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, r);
    n_checks++;
    if (r !== 32'hFFFF_FFFD) $display("FAIL div_m7_2: got %h required fffffffd", r);
    else n_pass++;
    release_res();
    run_op(OP_REM, 32'h8000_0000, 32'd3, lat, r);
    n_checks++;
    if (r !== 32'hFFFF_FFFE) $display("FAIL rem_min_3: got %h required fffffffe", r);
    else n_pass++;
    release_res();
    run_op(OP_DIV, 32'h8000_0000, 32'd3, lat, r);
    n_checks++;
    if (r !== 32'hD555_5556) $display("FAIL div_min_3: got %h required d5555556", r);
    else n_pass++;
    release_res();
    run_op(OP_DIV, 32'h0, 32'hFFFF_FFFB, lat, r);
    n_checks++;
    if (r !== 32'h0) $display("FAIL div_0_m5: got %h required 00000000", r);
    else n_pass++;
    release_res();
  endtask

  task automatic test_unsigned();
    int lat; logic [31:0] r;
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, lat, r);
    n_checks++;
    if ({r, lat} !== {32'hFFFF_FFFF, 32'd34}) $display("FAIL divu_max_1: got %h lat %0d required ffffffff lat 34", r, lat);
    else n_pass++;
    release_res();
    run_op(OP_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, lat, r);
    n_checks++;
    if (r !== 32'h1) $display("FAIL remu_max: got %h required 00000001", r);
    else n_pass++;
    release_res();
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, lat, r);
    n_checks++;
    if (r !== 32'h1) $display("FAIL divu_max: got %h required 00000001", r);
    else n_pass++;
    release_res();
  endtask

  task automatic test_fast_path();
    int lat; logic [31:0] r;
    run_op(OP_DIVU, 32'd5, 32'd0, lat, r);
    n_checks++;
    if ({r, lat} !== {32'hFFFF_FFFF, 32'd1}) $display("FAIL divu_by0: got %h lat %0d required ffffffff lat 1", r, lat);
    else n_pass++;
    release_res();
    run_op(OP_REMU, 32'd7, 32'd0, lat, r);
    n_checks++;
    if ({r, lat} !== {32'h7, 32'd1}) $display("FAIL remu_by0: got %h lat %0d required 00000007 lat 1", r, lat);
    else n_pass++;
    release_res();
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, r);
    n_checks++;
    if ({r, lat} !== {32'h8000_0000, 32'd1}) $display("FAIL div_ovf: got %h lat %0d required 80000000 lat 1", r, lat);
    else n_pass++;
    release_res();
    run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, lat, r);
    n_checks++;
    if ({r, lat} !== {32'h0, 32'd1}) $display("FAIL rem_ovf: got %h lat %0d required 00000000 lat 1", r, lat);
    else n_pass++;
    release_res();
    run_op(3'b000, 32'd9, 32'd3, lat, r);
    n_checks++;
    if ({r, lat} !== {32'h0, 32'd1}) $display("FAIL illegal_op: got %h lat %0d required 00000000 lat 1", r, lat);
    else n_pass++;
    release_res();
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] r;
    run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, lat, r);
    n_checks++;
    if (r !== 32'hFFFF_FFFF) $display("FAIL rem_m7_2: got %h required ffffffff", r);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({res_valid_o, req_ready_o, res_o} !== {1'b1, 1'b0, 32'hFFFF_FFFF})
        $display("FAIL hold_%0d: got valid=%b ready=%b res=%h required 1 0 ffffffff", i, res_valid_o, req_ready_o, res_o);
      else n_pass++;
    end
    release_res();
    n_checks++;
    if ({res_valid_o, busy_o, req_ready_o} !== 3'b001) $display("FAIL hold_release: got valid=%b busy=%b ready=%b required 0 0 1", res_valid_o, busy_o, req_ready_o);
    else n_pass++;
  endtask

  task automatic test_kill();
    int lat; logic [31:0] r; logic seen;
    op_i = OP_DIVU; a_i = 32'd1000; b_i = 32'd3; req_valid_i = 1'b1;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    kill_i = 1'b1;
    n_checks++;
    if (req_ready_o !== 1'b0) $display("FAIL kill_ready_low: got %b required 0", req_ready_o);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({res_valid_o, busy_o} !== 2'b00) $display("FAIL kill_iter: got valid=%b busy=%b required 0 0", res_valid_o, busy_o);
    else n_pass++;
    kill_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (res_valid_o || busy_o) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL kill_residue: got activity=%b required 0", seen);
    else n_pass++;
    run_op(OP_DIVU, 32'd100, 32'd7, lat, r);
    n_checks++;
    if ({r, lat} !== {32'd14, 32'd34}) $display("FAIL divu_100_7: got %h lat %0d required 0000000e lat 34", r, lat);
    else n_pass++;
    kill_i = 1'b1;
    @(posedge clk); #1;
    kill_i = 1'b0;
    n_checks++;
    if ({res_valid_o, busy_o} !== 2'b00) $display("FAIL kill_done: got valid=%b busy=%b required 0 0", res_valid_o, busy_o);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] r;
    op_i = OP_DIV; a_i = 32'd12345; b_i = 32'd7; req_valid_i = 1'b1;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({res_valid_o, busy_o, res_o} !== {1'b0, 1'b0, 32'h0}) $display("FAIL reset_mid: got valid=%b busy=%b res=%h required 0 0 00000000", res_valid_o, busy_o, res_o);
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(OP_REMU, 32'd100, 32'd7, lat, r);
    n_checks++;
    if ({r, lat} !== {32'd2, 32'd34}) $display("FAIL remu_after_reset: got %h lat %0d required 00000002 lat 34", r, lat);
    else n_pass++;
    release_res();
  endtask

  initial begin
    test_reset();
    test_signed();
    test_unsigned();
    test_fast_path();
    test_backpressure();
    test_kill();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
